gate_response_checker: RTL and testbench

Synthesizable self-checking endpoint for the basic two-input gate blocks. It is the receiving side of gate stimulus: it accepts one (A, B) vector at a time through a valid/ready handshake. After a programmable settle time it samples the gate-under-test output Q and compares it against a truth-table model selected by gate_sel. It counts vectors and mismatches, and reports a final pass/fail verdict so gate checks can run in hardware or on-board, not only in simulation.

---
 rtl/gate_check_pkg.sv | 38 +++
 rtl/gate_ref_model.sv | 16 +
 rtl/gate_response_checker.sv | 185 ++++++++++++++++++
 tb/tb_gate_response_checker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate response checker: gate_sel encodings,
// FSM state type and the reference truth-table function.
package gate_check_pkg;

  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_OR   = 3'd1;
  localparam logic [2:0] GATE_NAND = 3'd2;
  localparam logic [2:0] GATE_NOR  = 3'd3;
  localparam logic [2:0] GATE_XOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;
  localparam logic [2:0] GATE_NOT  = 3'd6;
  localparam logic [2:0] GATE_BUF  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } gate_state_e;

  function automatic logic gate_expected(input logic [2:0] sel, input logic a, input logic b);
    logic y;
    case (sel)
      GATE_AND:  y = a & b;
      GATE_OR:   y = a | b;
      GATE_NAND: y = ~(a & b);
      GATE_NOR:  y = ~(a | b);
      GATE_XOR:  y = a ^ b;
      GATE_XNOR: y = ~(a ^ b);
      GATE_NOT:  y = ~a;
      GATE_BUF:  y = a;
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational truth table for the two-input gate family (sel, a, b -> expected).
module gate_ref_model
  import gate_check_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       expected
);

  // Expected gate output for the captured vector
  always_comb begin
    expected = gate_expected(sel, a, b);
  end

endmodule

// File: rtl/gate_response_checker.sv
// Receiving endpoint for gate stimulus: accepts (A,B) vectors, samples Q after a
// settle delay, counts vectors/mismatches and produces a pass/fail verdict.
// Optional input-coverage tracking is enabled with GATE_CHECK_COVERAGE_EN.
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             end_test,
  input  logic [2:0]       gate_sel,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             vec_a,
  input  logic             vec_b,
  input  logic             q,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             done,
  output logic             pass,
  output logic [3:0]       cov_mask
);

  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

  gate_state_e      state_r;
  logic [7:0]       settle_cnt_r;
  logic             a_r;
  logic             b_r;
  logic [2:0]       sel_r;
  logic             end_pend_r;
  logic             vec_ready_r;
  logic             mismatch_r;
  logic             done_r;
  logic             pass_r;
  logic [CNT_W-1:0] vec_count_r;
  logic [CNT_W-1:0] err_count_r;
  logic [3:0]       cov_r;

  logic             expected_s;
  logic             miss_s;
  logic [CNT_W-1:0] vec_nxt_s;
  logic [CNT_W-1:0] err_nxt_s;
  logic [3:0]       cov_nxt_s;
  logic             cov_ok_cur_s;
  logic             cov_ok_nxt_s;

  function automatic logic verdict(input logic [CNT_W-1:0] errs,
                                   input logic [CNT_W-1:0] vecs,
                                   input logic             cov_ok);
    return (errs == CNT_ZERO) && (vecs != CNT_ZERO) && cov_ok;
  endfunction

  gate_ref_model u_ref (
    .sel      (sel_r),
    .a        (a_r),
    .b        (b_r),
    .expected (expected_s)
  );

  // Counter and coverage values as they would be after the current compare
  always_comb begin
    miss_s    = (q != expected_s);
    vec_nxt_s = vec_count_r + CNT_ONE;
    if (miss_s && (err_count_r != CNT_MAX)) begin
      err_nxt_s = err_count_r + CNT_ONE;
    end else begin
      err_nxt_s = err_count_r;
    end
`ifdef GATE_CHECK_COVERAGE_EN
    cov_nxt_s    = cov_r | (4'b0001 << {a_r, b_r});
    cov_ok_cur_s = (cov_r == 4'b1111);
    cov_ok_nxt_s = (cov_nxt_s == 4'b1111);
`else
    cov_nxt_s    = 4'b0000;
    cov_ok_cur_s = 1'b1;
    cov_ok_nxt_s = 1'b1;
`endif
  end

  // Main FSM with counters and registered verdict outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= 8'd0;
      a_r          <= 1'b0;
      b_r          <= 1'b0;
      sel_r        <= 3'd0;
      end_pend_r   <= 1'b0;
      vec_ready_r  <= 1'b0;
      mismatch_r   <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      vec_count_r  <= CNT_ZERO;
      err_count_r  <= CNT_ZERO;
      cov_r        <= 4'b0000;
    end else if (start) begin
      // start from any state aborts whatever is in flight
      state_r      <= ST_RUN;
      settle_cnt_r <= 8'd0;
      end_pend_r   <= 1'b0;
      vec_ready_r  <= 1'b1;
      mismatch_r   <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      vec_count_r  <= CNT_ZERO;
      err_count_r  <= CNT_ZERO;
      cov_r        <= 4'b0000;
    end else begin
      mismatch_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          vec_ready_r <= 1'b0;
        end
        ST_RUN: begin
          if (vec_valid) begin
            a_r          <= vec_a;
            b_r          <= vec_b;
            sel_r        <= gate_sel;
            settle_cnt_r <= SETTLE_LOAD;
            end_pend_r   <= end_test;
            vec_ready_r  <= 1'b0;
            state_r      <= ST_SETTLE;
          end else if (end_test) begin
            vec_ready_r <= 1'b0;
            done_r      <= 1'b1;
            pass_r      <= verdict(err_count_r, vec_count_r, cov_ok_cur_s);
            state_r     <= ST_DONE;
          end else begin
            vec_ready_r <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (end_test) begin
            end_pend_r <= 1'b1;
          end
          if (settle_cnt_r == 8'd0) begin
            state_r <= ST_COMPARE;
          end else begin
            settle_cnt_r <= settle_cnt_r - 8'd1;
          end
        end
        ST_COMPARE: begin
          mismatch_r  <= miss_s;
          vec_count_r <= vec_nxt_s;
          err_count_r <= err_nxt_s;
          cov_r       <= cov_nxt_s;
          if (end_pend_r || end_test) begin
            end_pend_r <= 1'b0;
            done_r     <= 1'b1;
            pass_r     <= verdict(err_nxt_s, vec_nxt_s, cov_ok_nxt_s);
            state_r    <= ST_DONE;
          end else begin
            vec_ready_r <= 1'b1;
            state_r     <= ST_RUN;
          end
        end
        ST_DONE: begin
          vec_ready_r <= 1'b0;
        end
        default: begin
          vec_ready_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign vec_ready = vec_ready_r;
  assign mismatch  = mismatch_r;
  assign vec_count = vec_count_r;
  assign err_count = err_count_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign cov_mask  = cov_r;

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker: random vectors against a truth-table
// reference, expected results queued at acceptance and checked by a monitor.
module tb_gate_response_checker;

  localparam int S  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          end_test = 1'b0;
  logic [2:0]    gate_sel = 3'd0;
  logic          vec_valid = 1'b0;
  logic          vec_ready;
  logic          vec_a = 1'b0;
  logic          vec_b = 1'b0;
  logic          q = 1'b0;
  logic          mismatch;
  logic [CW-1:0] vec_count;
  logic [CW-1:0] err_count;
  logic          done;
  logic          pass;
  logic [3:0]    cov_mask;

  gate_response_checker #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .end_test(end_test),
    .gate_sel(gate_sel), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_a(vec_a), .vec_b(vec_b), .q(q), .mismatch(mismatch),
    .vec_count(vec_count), .err_count(err_count), .done(done), .pass(pass),
    .cov_mask(cov_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mis;
    logic [CW-1:0] vec;
    logic [CW-1:0] err;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            clr_flag = 1'b0;
  logic [CW-1:0] m_vec = '0;
  logic [CW-1:0] m_err = '0;
  logic [3:0]    m_cov = 4'b0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Truth columns indexed by {a,b}
  function automatic logic ref_out(input logic [2:0] sel, input logic a, input logic b);
    logic [3:0] col;
    case (sel)
      3'd0: col = 4'b1000;
      3'd1: col = 4'b1110;
      3'd2: col = 4'b0111;
      3'd3: col = 4'b0001;
      3'd4: col = 4'b0110;
      3'd5: col = 4'b1001;
      3'd6: col = 4'b0011;
      default: col = 4'b1100;
    endcase
    return col[{a, b}];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_vec = '0;
    m_err = '0;
    m_cov = 4'b0000;
    clr_flag = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    model_clear();
  endtask

  // qmode: 0 correct q, 1 q forced 0, 2 q inverted
  task automatic send(input logic a, input logic b, input logic [2:0] sel,
                      input int qmode, input bit hold, input bit end_after);
    logic e;
    logic qv;
    int   n;
    int   low;
    e  = ref_out(sel, a, b);
    qv = (qmode == 0) ? e : ((qmode == 1) ? 1'b0 : ~e);
    vec_a = a; vec_b = b; gate_sel = sel; vec_valid = 1'b1; q = ~qv;
    n = 0;
    while (!vec_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!vec_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      vec_valid = 1'b0;
      return;
    end
    @(posedge clk);
    m_vec = m_vec + 1'b1;
    if (qv !== e && m_err != {CW{1'b1}}) m_err = m_err + 1'b1;
    m_cov = m_cov | (4'b0001 << {a, b});
    exp_q.push_back('{qv !== e, m_vec, m_err});
    #1;
    if (!hold) vec_valid = 1'b0;
    low = 0;
    for (int k = 0; k <= S; k++) begin
      q = (k == S) ? qv : ~qv;
      if (end_after) end_test = (k == 0);
      @(negedge clk);
      if (!vec_ready) low++;
      @(posedge clk);
      #1;
    end
    q = ~qv;
    end_test = 1'b0;
    @(negedge clk);
    if (!end_after) begin
      chk("ready_low_cycles", low, S + 1);
      chk("ready_back", vec_ready, 1'b1);
    end
  endtask

  task automatic verdict_check();
    int   n;
    logic ep;
    logic [3:0] ec;
    n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
`ifdef GATE_CHECK_COVERAGE_EN
    ep = (m_err == '0) && (m_vec != '0) && (m_cov == 4'b1111);
    ec = m_cov;
`else
    ep = (m_err == '0) && (m_vec != '0);
    ec = 4'b0000;
`endif
    chk("done", done, 1'b1);
    chk("pass", pass, ep);
    chk("final_vec_count", vec_count, m_vec);
    chk("final_err_count", err_count, m_err);
    chk("cov_mask", cov_mask, ec);
    chk("ready_in_done", vec_ready, 1'b0);
  endtask

  task automatic end_and_check();
    end_test = 1'b1;
    @(posedge clk);
    #1 end_test = 1'b0;
    verdict_check();
  endtask

  // Monitor: pops one expectation whenever the DUT presents a new result
  initial begin
    logic [CW-1:0] prev;
    exp_t x;
    prev = '0;
    forever begin
      @(negedge clk);
      if (clr_flag) begin
        chk("clr_vec_count", vec_count, '0);
        chk("clr_err_count", err_count, '0);
        chk("clr_done", done, 1'b0);
        chk("clr_cov", cov_mask, 4'b0000);
        clr_flag = 1'b0;
        prev = vec_count;
      end else if (vec_count !== prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          x = exp_q.pop_front();
          chk("vec_count", vec_count, x.vec);
          chk("err_count", err_count, x.err);
          chk("mismatch", mismatch, x.mis);
        end
        prev = vec_count;
      end else begin
        chk("mismatch_idle", mismatch, 1'b0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic a, b;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", vec_ready, 1'b0);
    chk("rst_vec", vec_count, '0);
    chk("rst_err", err_count, '0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_cov", cov_mask, 4'b0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", vec_ready, 1'b0);

    // XNOR all four vectors, correct q, back-to-back with vec_valid held
    do_start();
    for (int i = 0; i < 4; i++) send(i[1], i[0], 3'd5, 0, (i != 3), 1'b0);
    end_and_check();

    // XNOR with q stuck at 0
    do_start();
    for (int i = 0; i < 4; i++) send(i[1], i[0], 3'd5, 1, 1'b0, 1'b0);
    end_and_check();

    // end_test one cycle after an accept
    do_start();
    send(1'b1, 1'b0, 3'($urandom_range(7, 0)), 0, 1'b0, 1'b1);
    verdict_check();

    // start in SETTLE aborts the in-flight vector
    do_start();
    for (int i = 0; i < 3; i++) send(1'($urandom), 1'($urandom), 3'($urandom_range(7, 0)), 0, 1'b0, 1'b0);
    vec_a = 1'b1; vec_b = 1'b1; gate_sel = 3'd0; vec_valid = 1'b1;
    @(posedge clk);
    #1 vec_valid = 1'b0;
    do_start();
    @(negedge clk);
    chk("abort_ready", vec_ready, 1'b1);
    for (int i = 0; i < 2; i++) send(1'($urandom), 1'($urandom), 3'($urandom_range(7, 0)), 2, 1'b0, 1'b0);
    // reset mid-SETTLE
    vec_valid = 1'b1;
    @(posedge clk);
    #1 vec_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    chk("arst_vec", vec_count, '0);
    chk("arst_err", err_count, '0);
    chk("arst_ready", vec_ready, 1'b0);
    chk("arst_mismatch", mismatch, 1'b0);
    chk("arst_done", done, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", vec_ready, 1'b0);

    // Partial coverage: only 00 and 11
    do_start();
    send(1'b0, 1'b0, 3'd5, 0, 1'b0, 1'b0);
    send(1'b1, 1'b1, 3'd5, 0, 1'b0, 1'b0);
    end_and_check();

    // No vectors at all
    do_start();
    end_and_check();

    // 16 random correct vectors: vec_count wraps to 0
    do_start();
    for (int i = 0; i < 16; i++) send(1'($urandom), 1'($urandom), 3'($urandom_range(7, 0)), 0, (i != 15), 1'b0);
    end_and_check();

    // 17 wrong vectors: err_count saturates
    do_start();
    for (int i = 0; i < 17; i++) send(1'($urandom), 1'($urandom), 3'($urandom_range(7, 0)), 2, (i != 16), 1'b0);
    end_and_check();

    // Mixed random run
    do_start();
    for (int i = 0; i < 12; i++) begin
      a = 1'($urandom);
      b = 1'($urandom);
      send(a, b, 3'($urandom_range(7, 0)), ($urandom_range(3, 0) == 0) ? 2 : 0, 1'b0, 1'b0);
    end
    end_and_check();

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
